dmem_bus_master: RTL and testbench
==================================

# dmem_bus_master

Processor-side initiator for the external data-memory bus. It accepts one load or store from the MEM stage, drives DAD/MREQ/WRITE/SIZE/DDT, and waits for the memory's active-low acknowledge ACKD_n. It returns sign- or zero-extended load data, or a completion/error pulse, to the pipeline. It sits inside `top`, between the MEM stage and the DAD/MREQ/WRITE/SIZE/DDT/ACKD_n pins.

## Interface
- BIT_WIDTH, 32, data/address width
- TIMEOUT, 255, cycles in ACCESS without acknowledge before abort (counter width 8)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_req  in  1  start request; sampled only in IDLE
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  00 word, 01 half, 10 byte, 11 illegal
- mem_signed  in  1  sign-extend load result
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, right-justified
- mem_busy  out  1  transaction in progress; pipeline stall
- mem_done  out  1  one-cycle completion pulse
- mem_err  out  1  valid with mem_done: misaligned, illegal size, or timeout
- mem_rdata  out  32  load result, valid with mem_done
- DAD  out  32  bus address
- MREQ  out  1  bus request, active-high
- WRITE  out  1  1 = store cycle
- SIZE  out  2  same encoding as mem_size
- DDT  inout  32  bus data; driven only during store ACCESS, else high-Z
- ACKD_n  in  1  memory acknowledge, active-low

## Operation
- States: IDLE, ACCESS, FAULT.
- **IDLE.** If mem_req=1, register addr/we/size/signed/wdata.
  - If legal: go to ACCESS.
  - If misaligned or illegal: go to FAULT. Misaligned means word with addr[1:0]≠0, or half with addr[0]≠0. Illegal means size=11.
  - ACKD_n is ignored in IDLE.
- **ACCESS.**
  - Outputs: MREQ=1; DAD, WRITE, SIZE from registers.
  - On a store, DDT carries the right-justified data: word on [31:0], half on [15:0] with upper bits 0, byte on [7:0] with upper bits 0.
  - Timeout counter increments each cycle.
  - If ACKD_n=0 at the edge:
    - A load captures DDT. Memory returns data right-justified and zero-filled. Extend it per size/signed via load_extend.
    - Go to IDLE with mem_done=1, mem_err=0.
  - If the counter reaches TIMEOUT: go to IDLE with mem_done=1, mem_err=1, mem_rdata=0.
- **FAULT.** Lasts exactly one cycle, no bus activity, then IDLE with mem_done=1, mem_err=1, mem_rdata=0.
- mem_busy = (state≠IDLE) | (state=IDLE & mem_req).
- mem_rdata holds its value until the next mem_done.
- Stores return mem_rdata unchanged.
- No special-casing of the STDOUT (0xf0000000) or EXIT (0xff000000) addresses; they are ordinary bus cycles.

## Timing
- Reset values: MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT high-Z, mem_done=0, mem_err=0, mem_rdata=0, mem_busy=0 (mem_req low), state IDLE, counter 0.
- Reset asserted mid-ACCESS: MREQ drops and DDT releases immediately (asynchronous); no mem_done.
- All bus outputs are registered and stable for the whole ACCESS. No combinational path from ACKD_n to bus outputs.
- Latency: with memory acknowledging after L cycles of MREQ, mem_done rises L+1 cycles after the mem_req edge. L=1 gives 2 cycles.
- MREQ falls in the same cycle mem_done is high.
- Back-to-back: mem_req high in the mem_done cycle starts a new transaction. The requester must drop mem_req in that cycle unless it intends a new one.
- Fault path: mem_done 2 cycles after mem_req.
- Acknowledge and timeout in the same cycle: acknowledge wins; mem_err=0.

## Structure
- Package mem_pkg holds:
  - size codes SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - the state enum;
  - STDOUT_ADDR/EXIT_ADDR constants, shared with the bench.
- Sub-module load_extend: combinational, inputs raw[31:0], size, signed; output 32-bit extended value.
- Tristate on DDT is done in this block, not in `top`.

## Test plan
- Word load at 0x100, memory holds DE AD BE EF, latency 1 -> MREQ=1 one cycle; mem_done on cycle 2; mem_rdata=0xDEADBEEF, mem_err=0.
- Signed byte load of 0x80 at 0x103 -> 0xFFFFFF80; unsigned -> 0x00000080. Signed half load of 0x8001 -> 0xFFFF8001.
- Byte store 0x41 to 0xf0000000 -> SIZE=10, WRITE=1, DDT[7:0]=0x41 while MREQ=1; bench prints "A"; DDT high-Z after mem_done.
- Half load at 0x101 -> no MREQ; mem_done+mem_err on cycle 2. Same result for size=11.
- ACKD_n held high, TIMEOUT=4 -> MREQ high 4 cycles, then mem_done+mem_err, mem_rdata=0. Separately, rst low mid-ACCESS -> MREQ=0, DDT=Z at once, no mem_done.
- Back-to-back store then load with mem_req held through mem_done -> second MREQ the cycle after the first mem_done; both complete without error.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory bus master: size codes, FSM states, magic addresses.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    // Memory-mapped console and simulation-exit addresses; plain bus cycles here.
    localparam logic [31:0] STDOUT_ADDR = 32'hf000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'hff00_0000;

    // A request may go to the bus only if its size is defined and the address
    // is naturally aligned for that size.
    function automatic logic req_legal(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: return (addr_lo == 2'b00);
            SZ_HALF: return !addr_lo[0];
            SZ_BYTE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero-extends right-justified load data according to access size.
// Latency: combinational.
// Backpressure: none.
// Ports: raw (bus data), size (mem_pkg size code), is_signed, ext (extended result).
module load_extend
    import mem_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] raw,
    input  logic [1:0]   size,
    input  logic         is_signed,
    output logic [W-1:0] ext
);

    // Memory zero-fills above the accessed lane, so only the low lane is trusted.
    always_comb begin
        ext = raw;
        case (size)
            SZ_HALF: ext = {{(W-16){is_signed & raw[15]}}, raw[15:0]};
            SZ_BYTE: ext = {{(W-8){is_signed & raw[7]}}, raw[7:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/dmem_bus_master.sv
// Single-outstanding initiator for the external data-memory bus (DAD/MREQ/WRITE/SIZE/DDT, ACKD_n).
// Latency: mem_done L+1 cycles after the request edge for an L-cycle acknowledge; faults in 2.
// Backpressure: mem_busy stalls the pipeline; ACCESS aborts with mem_err after TIMEOUT cycles.
// Ports: pipeline side mem_req/we/size/signed/addr/wdata in, mem_busy/done/err/rdata out;
//        bus side DAD/MREQ/WRITE/SIZE out, DDT bidirectional, ACKD_n in (active-low).
module dmem_bus_master
    import mem_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_req,
    input  logic                 mem_we,
    input  logic [1:0]           mem_size,
    input  logic                 mem_signed,
    input  logic [BIT_WIDTH-1:0] mem_addr,
    input  logic [BIT_WIDTH-1:0] mem_wdata,
    output logic                 mem_busy,
    output logic                 mem_done,
    output logic                 mem_err,
    output logic [BIT_WIDTH-1:0] mem_rdata,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    inout  wire  [BIT_WIDTH-1:0] DDT,
    input  logic                 ACKD_n
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t               state, state_nxt;
    logic [7:0]           cnt;
    logic [7:0]           cnt_inc;
    logic                 signed_q;
    logic                 ddt_oe;
    logic [BIT_WIDTH-1:0] ddt_out;
    logic                 req_ok;
    logic                 ack;
    logic                 expired;
    logic [BIT_WIDTH-1:0] load_val;
    logic [BIT_WIDTH-1:0] store_val;

    assign req_ok  = req_legal(mem_size, mem_addr[1:0]);
    assign ack     = !ACKD_n;
    assign cnt_inc = cnt + 8'd1;
    // The cycle whose increment would reach the limit is the last one allowed.
    assign expired = (cnt_inc == TO_LIM);

    assign mem_busy = (state != ST_IDLE) || ((state == ST_IDLE) && mem_req);

    // Output enable is a flop with async clear, so reset releases the bus at once.
    assign DDT = ddt_oe ? ddt_out : 'z;

    // Store data goes out right-justified with the unused upper lanes forced to zero.
    always_comb begin
        store_val = mem_wdata;
        case (mem_size)
            SZ_HALF: store_val = {{(BIT_WIDTH-16){1'b0}}, mem_wdata[15:0]};
            SZ_BYTE: store_val = {{(BIT_WIDTH-8){1'b0}}, mem_wdata[7:0]};
            default: store_val = mem_wdata;
        endcase
    end

    load_extend #(
        .W (BIT_WIDTH)
    ) u_load_extend (
        .raw       (DDT),
        .size      (SIZE),
        .is_signed (signed_q),
        .ext       (load_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    state_nxt = req_ok ? ST_ACCESS : ST_FAULT;
                end
            end
            ST_ACCESS: begin
                if (ack || expired) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FAULT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MREQ      <= 1'b0;
            WRITE     <= 1'b0;
            SIZE      <= SZ_WORD;
            DAD       <= '0;
            ddt_oe    <= 1'b0;
            ddt_out   <= '0;
            signed_q  <= 1'b0;
            cnt       <= '0;
            mem_done  <= 1'b0;
            mem_err   <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // ACKD_n is deliberately not looked at here.
                    if (mem_req && req_ok) begin
                        MREQ     <= 1'b1;
                        WRITE    <= mem_we;
                        SIZE     <= mem_size;
                        DAD      <= mem_addr;
                        signed_q <= mem_signed;
                        ddt_out  <= store_val;
                        ddt_oe   <= mem_we;
                        cnt      <= '0;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt_inc;
                    if (ack || expired) begin
                        MREQ     <= 1'b0;
                        WRITE    <= 1'b0;
                        ddt_oe   <= 1'b0;
                        mem_done <= 1'b1;
                        // Acknowledge beats a simultaneous timeout.
                        mem_err  <= !ack;
                        if (ack) begin
                            if (!WRITE) begin
                                mem_rdata <= load_val;
                            end
                        end else begin
                            mem_rdata <= '0;
                        end
                    end
                end
                ST_FAULT: begin
                    mem_done  <= 1'b1;
                    mem_err   <= 1'b1;
                    mem_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_master.sv
// Directed self-checking bench for dmem_bus_master with a hand-driven memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_bus_master;
    import mem_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_err;
    logic [31:0] mem_rdata;
    logic [31:0] DAD;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    wire  [31:0] DDT;
    logic        ACKD_n;

    // Bench side of DDT: returns load data, otherwise holds the bus at zero
    // whenever the DUT is expected to be released, so a stray driver shows up.
    logic [31:0] ddt_tb;
    logic        ddt_tb_en;
    assign DDT = ddt_tb_en ? ddt_tb : 'z;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    dmem_bus_master #(
        .BIT_WIDTH (32),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_signed (mem_signed),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done),
        .mem_err    (mem_err),
        .mem_rdata  (mem_rdata),
        .DAD        (DAD),
        .MREQ       (MREQ),
        .WRITE      (WRITE),
        .SIZE       (SIZE),
        .DDT        (DDT),
        .ACKD_n     (ACKD_n)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r, input logic we, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd);
        mem_req    = r;
        mem_we     = we;
        mem_size   = sz;
        mem_signed = sg;
        mem_addr   = a;
        mem_wdata  = wd;
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        set_req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        ACKD_n    = 1'b1;
        ddt_tb    = 32'h0;
        ddt_tb_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({MREQ, WRITE, SIZE, mem_done, mem_err, mem_busy} !== 7'b0) begin
            err_cnt++;
            $display("FAIL reset ctrl: got %b expected 0000000",
                     {MREQ, WRITE, SIZE, mem_done, mem_err, mem_busy});
        end
        vec_cnt++;
        if (DAD !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset DAD: got %h expected 00000000", DAD);
        end
        vec_cnt++;
        if (mem_rdata !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset rdata: got %h expected 00000000", mem_rdata);
        end
        vec_cnt++;
        if (DDT !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset DDT released: got %h expected 00000000", DDT);
        end
        rst = 1'b1;
        // Acknowledge while idle must be ignored.
        tick;
        ACKD_n = 1'b0;
        @(negedge clk);
        tick;
        ACKD_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({MREQ, mem_done, mem_busy} !== 3'b000) begin
            err_cnt++;
            $display("FAIL idle ack ignored: got %b expected 000", {MREQ, mem_done, mem_busy});
        end
    endtask

    task automatic test_load(input string name, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] raw, input logic [31:0] exp);
        tick;
        set_req(1'b1, 1'b0, sz, sg, a, 32'h0);
        @(negedge clk);
        vec_cnt++;
        if ({mem_busy, MREQ} !== 2'b10) begin
            err_cnt++;
            $display("FAIL %s req cycle busy/mreq: got %b expected 10", name, {mem_busy, MREQ});
        end
        tick;
        mem_req = 1'b0;
        ACKD_n  = 1'b0;
        ddt_tb  = raw;
        @(negedge clk);
        vec_cnt++;
        if ({MREQ, WRITE, SIZE, mem_done} !== {1'b1, 1'b0, sz, 1'b0}) begin
            err_cnt++;
            $display("FAIL %s access mreq/write/size/done: got %b expected %b", name,
                     {MREQ, WRITE, SIZE, mem_done}, {1'b1, 1'b0, sz, 1'b0});
        end
        vec_cnt++;
        if (DAD !== a) begin
            err_cnt++;
            $display("FAIL %s DAD: got %h expected %h", name, DAD, a);
        end
        tick;
        ACKD_n = 1'b1;
        ddt_tb = 32'h0;
        @(negedge clk);
        vec_cnt++;
        if ({mem_done, mem_err, MREQ} !== 3'b100) begin
            err_cnt++;
            $display("FAIL %s done/err/mreq: got %b expected 100", name, {mem_done, mem_err, MREQ});
        end
        vec_cnt++;
        if (mem_rdata !== exp) begin
            err_cnt++;
            $display("FAIL %s rdata: got %h expected %h", name, mem_rdata, exp);
        end
    endtask

    task automatic test_store(input logic [31:0] prev_rdata);
        tick;
        set_req(1'b1, 1'b1, SZ_BYTE, 1'b0, STDOUT_ADDR, 32'hAAAA_AA41);
        tick;
        mem_req   = 1'b0;
        ddt_tb_en = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({MREQ, WRITE, SIZE} !== 4'b1110) begin
            err_cnt++;
            $display("FAIL store mreq/write/size: got %b expected 1110", {MREQ, WRITE, SIZE});
        end
        vec_cnt++;
        if (DAD !== STDOUT_ADDR) begin
            err_cnt++;
            $display("FAIL store DAD: got %h expected %h", DAD, STDOUT_ADDR);
        end
        vec_cnt++;
        if (DDT !== 32'h0000_0041) begin
            err_cnt++;
            $display("FAIL store DDT: got %h expected 00000041", DDT);
        end
        $display("stdout: %c", DDT[7:0]);
        tick;
        ACKD_n = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({MREQ, DDT} !== {1'b1, 32'h0000_0041}) begin
            err_cnt++;
            $display("FAIL store held 2nd cycle: got %b/%h expected 1/00000041", MREQ, DDT);
        end
        tick;
        ACKD_n    = 1'b1;
        ddt_tb_en = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({mem_done, mem_err, MREQ, WRITE} !== 4'b1000) begin
            err_cnt++;
            $display("FAIL store done/err/mreq/write: got %b expected 1000",
                     {mem_done, mem_err, MREQ, WRITE});
        end
        vec_cnt++;
        if (mem_rdata !== prev_rdata) begin
            err_cnt++;
            $display("FAIL store rdata kept: got %h expected %h", mem_rdata, prev_rdata);
        end
        vec_cnt++;
        if (DDT !== 32'h0) begin
            err_cnt++;
            $display("FAIL store DDT released: got %h expected 00000000", DDT);
        end
    endtask

    task automatic test_fault(input string name, input logic [1:0] sz, input logic [31:0] a);
        tick;
        set_req(1'b1, 1'b0, sz, 1'b0, a, 32'h0);
        tick;
        mem_req = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({MREQ, mem_done, mem_busy} !== 3'b001) begin
            err_cnt++;
            $display("FAIL %s fault cycle mreq/done/busy: got %b expected 001", name,
                     {MREQ, mem_done, mem_busy});
        end
        tick;
        @(negedge clk);
        vec_cnt++;
        if ({mem_done, mem_err, MREQ} !== 3'b110) begin
            err_cnt++;
            $display("FAIL %s done/err/mreq: got %b expected 110", name, {mem_done, mem_err, MREQ});
        end
        vec_cnt++;
        if (mem_rdata !== 32'h0) begin
            err_cnt++;
            $display("FAIL %s rdata: got %h expected 00000000", name, mem_rdata);
        end
        tick;
        @(negedge clk);
        vec_cnt++;
        if (mem_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s done one cycle: got %b expected 0", name, mem_done);
        end
    endtask

    task automatic test_back_to_back;
        tick;
        set_req(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0000_0200, 32'h1122_3344);
        tick;
        // Next request already presented; the master only samples it once idle.
        set_req(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h0000_0206, 32'h0);
        ddt_tb_en = 1'b0;
        ACKD_n    = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({MREQ, WRITE, DDT} !== {2'b11, 32'h1122_3344}) begin
            err_cnt++;
            $display("FAIL b2b store bus: got %b/%h expected 11/11223344", {MREQ, WRITE}, DDT);
        end
        tick;
        ACKD_n    = 1'b1;
        ddt_tb_en = 1'b1;
        ddt_tb    = 32'h0;
        @(negedge clk);
        vec_cnt++;
        if ({mem_done, mem_err, MREQ, mem_busy} !== 4'b1001) begin
            err_cnt++;
            $display("FAIL b2b first done/err/mreq/busy: got %b expected 1001",
                     {mem_done, mem_err, MREQ, mem_busy});
        end
        tick;
        mem_req = 1'b0;
        ACKD_n  = 1'b0;
        ddt_tb  = 32'h0000_BEEF;
        @(negedge clk);
        vec_cnt++;
        if ({MREQ, WRITE, SIZE, mem_done} !== 5'b10010) begin
            err_cnt++;
            $display("FAIL b2b load bus: got %b expected 10010", {MREQ, WRITE, SIZE, mem_done});
        end
        vec_cnt++;
        if (DAD !== 32'h0000_0206) begin
            err_cnt++;
            $display("FAIL b2b load DAD: got %h expected 00000206", DAD);
        end
        tick;
        ACKD_n = 1'b1;
        ddt_tb = 32'h0;
        @(negedge clk);
        vec_cnt++;
        if ({mem_done, mem_err} !== 2'b10 || mem_rdata !== 32'h0000_BEEF) begin
            err_cnt++;
            $display("FAIL b2b load done/err rdata: got %b %h expected 10 0000beef",
                     {mem_done, mem_err}, mem_rdata);
        end
    endtask

    task automatic test_timeout;
        int  hi;
        bit  seen;
        hi   = 0;
        seen = 1'b0;
        tick;
        set_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0300, 32'h0);
        tick;
        mem_req = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (mem_done) begin
                seen = 1'b1;
            end else begin
                if (MREQ) hi++;
                tick;
            end
        end
        vec_cnt++;
        if (seen !== 1'b1) begin
            err_cnt++;
            $display("FAIL timeout done seen: got %b expected 1", seen);
        end
        vec_cnt++;
        if (hi != TO) begin
            err_cnt++;
            $display("FAIL timeout mreq cycles: got %0d expected %0d", hi, TO);
        end
        vec_cnt++;
        if ({mem_err, MREQ} !== 2'b10 || mem_rdata !== 32'h0) begin
            err_cnt++;
            $display("FAIL timeout err/mreq rdata: got %b %h expected 10 00000000",
                     {mem_err, MREQ}, mem_rdata);
        end
    endtask

    task automatic test_ack_at_limit;
        tick;
        set_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0304, 32'h0);
        tick;
        mem_req = 1'b0;
        tick;
        tick;
        tick;
        // Fourth MREQ cycle: acknowledge coincides with the timeout limit.
        ACKD_n = 1'b0;
        ddt_tb = 32'h0000_0055;
        @(negedge clk);
        vec_cnt++;
        if ({MREQ, mem_done} !== 2'b10) begin
            err_cnt++;
            $display("FAIL ack-at-limit still in access: got %b expected 10", {MREQ, mem_done});
        end
        tick;
        ACKD_n = 1'b1;
        ddt_tb = 32'h0;
        @(negedge clk);
        vec_cnt++;
        if ({mem_done, mem_err} !== 2'b10 || mem_rdata !== 32'h0000_0055) begin
            err_cnt++;
            $display("FAIL ack-at-limit done/err rdata: got %b %h expected 10 00000055",
                     {mem_done, mem_err}, mem_rdata);
        end
    endtask

    task automatic test_reset_mid_access;
        tick;
        set_req(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0000_0400, 32'hFFFF_FFFF);
        tick;
        mem_req   = 1'b0;
        ddt_tb_en = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({MREQ, DDT} !== {1'b1, 32'hFFFF_FFFF}) begin
            err_cnt++;
            $display("FAIL rst-mid pre bus: got %b/%h expected 1/ffffffff", MREQ, DDT);
        end
        tick;
        #2;
        rst       = 1'b0;
        ddt_tb_en = 1'b1;
        ddt_tb    = 32'h0;
        #1;
        vec_cnt++;
        if ({MREQ, WRITE, mem_busy} !== 3'b000) begin
            err_cnt++;
            $display("FAIL rst-mid async mreq/write/busy: got %b expected 000", {MREQ, WRITE, mem_busy});
        end
        vec_cnt++;
        if (DDT !== 32'h0) begin
            err_cnt++;
            $display("FAIL rst-mid DDT released: got %h expected 00000000", DDT);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (mem_done !== 1'b0) begin
                err_cnt++;
                $display("FAIL rst-mid no done (cycle %0d): got %b expected 0", i, mem_done);
            end
        end
        rst = 1'b1;
        tick;
        @(negedge clk);
        vec_cnt++;
        if ({mem_done, MREQ, mem_busy} !== 3'b000) begin
            err_cnt++;
            $display("FAIL rst-mid after release: got %b expected 000", {mem_done, MREQ, mem_busy});
        end
    endtask

    initial begin
        test_reset;
        test_load("word_load",  SZ_WORD, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        test_load("sbyte_load", SZ_BYTE, 1'b1, 32'h0000_0103, 32'h0000_0080, 32'hFFFF_FF80);
        test_load("ubyte_load", SZ_BYTE, 1'b0, 32'h0000_0103, 32'h0000_0080, 32'h0000_0080);
        test_load("shalf_load", SZ_HALF, 1'b1, 32'h0000_0102, 32'h0000_8001, 32'hFFFF_8001);
        test_store(32'hFFFF_8001);
        test_fault("misaligned_half", SZ_HALF, 32'h0000_0101);
        test_back_to_back;
        test_fault("illegal_size", SZ_ILL, 32'h0000_0100);
        test_load("exit_addr_load", SZ_WORD, 1'b0, EXIT_ADDR, 32'hCAFE_F00D, 32'hCAFE_F00D);
        test_timeout;
        test_ack_at_limit;
        test_reset_mid_access;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

endmodule
